// File: rtl/equiv_monitor_pkg.sv
// Shared types and default parameter values for the
// good/bad equivalence monitor.
package equiv_monitor_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } state_e;

   localparam int WIDTH_DEF      = 8;
   localparam int CNT_W_DEF      = 32;
   localparam int DEPTH_DEF      = 4;
   localparam int STOP_AFTER_DEF = 1;

endpackage

// File: rtl/equiv_log_fifo.sv
// First-word fall-through sync FIFO holding mismatch records.
// A push into a full FIFO is accepted only alongside a pop.
module equiv_log_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wptr_q, wptr_d;
   logic [AW:0]      rptr_q, rptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             wr;
   logic             rd;

   // Extra pointer bit tells full from empty when the indices match.
   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                    (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign rd      = pop_i && !empty_o;
   assign wr      = push_i && (!full_o || rd);
   assign data_o  = mem_q[rptr_q[AW-1:0]];

   always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (flush_i) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (wr) begin
            mem_d[wptr_q[AW-1:0]] = data_i;
            wptr_d = wptr_q + (AW+1)'(1);
         end
         if (rd) begin
            rptr_d = rptr_q + (AW+1)'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         mem_q  <= '{default: '0};
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         mem_q  <= mem_d;
      end
   end

endmodule

// File: rtl/equiv_monitor.sv
// Compares good/bad streams, counts cycles and mismatches,
// stops after STOP_AFTER mismatches and logs each one.
module equiv_monitor
   import equiv_monitor_pkg::*;
#(
   parameter int WIDTH      = WIDTH_DEF,
   parameter int CNT_W      = CNT_W_DEF,
   parameter int DEPTH      = DEPTH_DEF,
   parameter int STOP_AFTER = STOP_AFTER_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear_i,
   input  logic             check_en_i,
   input  logic [WIDTH-1:0] good_i,
   input  logic [WIDTH-1:0] bad_i,
   output logic [CNT_W-1:0] cycle_o,
   output logic [CNT_W-1:0] mismatch_cnt_o,
   output logic             fail_o,
   output logic             done_o,
   output logic             log_valid_o,
   input  logic             log_ready_i,
   output logic [CNT_W-1:0] log_cycle_o,
   output logic [WIDTH-1:0] log_good_o,
   output logic [WIDTH-1:0] log_bad_o,
   output logic             log_overflow_o
);

   typedef struct packed {
      logic [CNT_W-1:0] cyc;
      logic [WIDTH-1:0] good;
      logic [WIDTH-1:0] bad;
   } rec_t;

   localparam int RW = $bits(rec_t);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cycle_q, cycle_d;
   logic [CNT_W-1:0] mism_q, mism_d;
   logic             fail_q, fail_d;
   logic             ovf_q, ovf_d;
   logic             push;
   logic             pop;
   logic             full;
   logic             empty;
   logic             miss;
   rec_t             rec_in;
   rec_t             head;

   // Four-state compare so X/Z differences count as mismatches.
   assign miss   = (good_i !== bad_i);
   assign rec_in = '{cyc: cycle_q, good: good_i, bad: bad_i};
   assign pop    = !empty && log_ready_i && !clear_i;

   always_comb begin
      state_d = state_q;
      cycle_d = cycle_q;
      mism_d  = mism_q;
      fail_d  = fail_q;
      ovf_d   = ovf_q;
      push    = 1'b0;
      if (clear_i) begin
         state_d = IDLE;
         cycle_d = '0;
         mism_d  = '0;
         fail_d  = 1'b0;
         ovf_d   = 1'b0;
      end else if (check_en_i && state_q != STOP) begin
         if (state_q == IDLE) state_d = RUN;
         if (cycle_q != '1) cycle_d = cycle_q + CNT_W'(1);
         if (miss) begin
            if (mism_q != '1) mism_d = mism_q + CNT_W'(1);
            fail_d = 1'b1;
            push   = 1'b1;
            if (full && !pop) ovf_d = 1'b1;
            if (mism_d >= CNT_W'(STOP_AFTER)) state_d = STOP;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cycle_q <= '0;
         mism_q  <= '0;
         fail_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cycle_q <= cycle_d;
         mism_q  <= mism_d;
         fail_q  <= fail_d;
         ovf_q   <= ovf_d;
      end
   end

   equiv_log_fifo #(
      .WIDTH (RW),
      .DEPTH (DEPTH)
   ) u_log (
      .clk     (clk),
      .rst     (rst),
      .flush_i (clear_i),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  (rec_in),
      .data_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );

   assign cycle_o        = cycle_q;
   assign mismatch_cnt_o = mism_q;
   assign fail_o         = fail_q;
   assign done_o         = (state_q == STOP);
   assign log_overflow_o = ovf_q;
   assign log_valid_o    = !empty;
   assign log_cycle_o    = log_valid_o ? head.cyc  : '0;
   assign log_good_o     = log_valid_o ? head.good : '0;
   assign log_bad_o      = log_valid_o ? head.bad  : '0;

endmodule

// File: tb/tb_equiv_monitor.sv
// Bench: two monitors (stop after 1 and after 8) share stimulus
// and are checked against a queue-level reference model.
module tb_equiv_monitor;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clear = 1'b0;
   logic en = 1'b0;
   logic [7:0] good = '0;
   logic [7:0] bad = '0;
   logic rdy = 1'b0;

   logic [31:0] cyc_o [2];
   logic [31:0] mc_o [2];
   logic        fail_o [2];
   logic        done_o [2];
   logic        lv_o [2];
   logic [31:0] lc_o [2];
   logic [7:0]  lg_o [2];
   logic [7:0]  lb_o [2];
   logic        ovf_o [2];

   int n_checks = 0;
   int n_fail = 0;

   int          stop_n [2];
   logic [31:0] m_cyc [2];
   logic [31:0] m_mc [2];
   bit          m_fail [2];
   bit          m_ovf [2];
   bit          m_stop [2];
   int          m_n [2];
   logic [31:0] m_lc [2][4];
   logic [7:0]  m_lg [2][4];
   logic [7:0]  m_lb [2][4];

   always #5 clk = ~clk;

   equiv_monitor #(
      .WIDTH(8), .CNT_W(32), .DEPTH(4), .STOP_AFTER(1)
   ) u_dut1 (
      .clk(clk), .rst(rst), .clear_i(clear),
      .check_en_i(en), .good_i(good), .bad_i(bad),
      .cycle_o(cyc_o[0]), .mismatch_cnt_o(mc_o[0]),
      .fail_o(fail_o[0]), .done_o(done_o[0]),
      .log_valid_o(lv_o[0]), .log_ready_i(rdy),
      .log_cycle_o(lc_o[0]), .log_good_o(lg_o[0]),
      .log_bad_o(lb_o[0]), .log_overflow_o(ovf_o[0])
   );

   equiv_monitor #(
      .WIDTH(8), .CNT_W(32), .DEPTH(4), .STOP_AFTER(8)
   ) u_dut8 (
      .clk(clk), .rst(rst), .clear_i(clear),
      .check_en_i(en), .good_i(good), .bad_i(bad),
      .cycle_o(cyc_o[1]), .mismatch_cnt_o(mc_o[1]),
      .fail_o(fail_o[1]), .done_o(done_o[1]),
      .log_valid_o(lv_o[1]), .log_ready_i(rdy),
      .log_cycle_o(lc_o[1]), .log_good_o(lg_o[1]),
      .log_bad_o(lb_o[1]), .log_overflow_o(ovf_o[1])
   );

   task automatic model_clear();
      for (int i = 0; i < 2; i++) begin
         m_cyc[i] = 0;
         m_mc[i] = 0;
         m_fail[i] = 0;
         m_ovf[i] = 0;
         m_stop[i] = 0;
         m_n[i] = 0;
      end
   endtask

   task automatic model_step(input bit c, input bit e,
         input logic [7:0] g, input logic [7:0] b,
         input bit r);
      if (c) begin
         model_clear();
         return;
      end
      for (int i = 0; i < 2; i++) begin
         if (m_n[i] > 0 && r) begin
            for (int k = 0; k < 3; k++) begin
               m_lc[i][k] = m_lc[i][k+1];
               m_lg[i][k] = m_lg[i][k+1];
               m_lb[i][k] = m_lb[i][k+1];
            end
            m_n[i]--;
         end
         if (e && !m_stop[i]) begin
            if (g !== b) begin
               if (m_n[i] < 4) begin
                  m_lc[i][m_n[i]] = m_cyc[i];
                  m_lg[i][m_n[i]] = g;
                  m_lb[i][m_n[i]] = b;
                  m_n[i]++;
               end else begin
                  m_ovf[i] = 1;
               end
               m_mc[i]++;
               m_fail[i] = 1;
               if (m_mc[i] >= stop_n[i]) m_stop[i] = 1;
            end
            m_cyc[i]++;
         end
      end
   endtask

   task automatic tick(input bit c, input bit e,
         input logic [7:0] g, input logic [7:0] b,
         input bit r);
      clear = c;
      en = e;
      good = g;
      bad = b;
      rdy = r;
      @(posedge clk);
      model_step(c, e, g, b, r);
      #1;
   endtask

   task automatic test_reset();
      model_clear();
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if ({cyc_o[i], mc_o[i], fail_o[i], done_o[i],
              lv_o[i], ovf_o[i]} !== '0) begin
            n_fail++;
            $display("FAIL reset_state[%0d]: cyc=%0d mc=%0d f=%b d=%b v=%b o=%b want 0",
               i, cyc_o[i], mc_o[i], fail_o[i], done_o[i],
               lv_o[i], ovf_o[i]);
         end
         n_checks++;
         if ({lc_o[i], lg_o[i], lb_o[i]} !== '0) begin
            n_fail++;
            $display("FAIL reset_log[%0d]: got %h/%h/%h want 0",
               i, lc_o[i], lg_o[i], lb_o[i]);
         end
      end
   endtask

   task automatic test_equal();
      tick(1, 0, 0, 0, 0);
      for (int k = 0; k < 10; k++) tick(0, 1, 8'h5A, 8'h5A, 0);
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (cyc_o[i] !== m_cyc[i] || mc_o[i] !== m_mc[i]) begin
            n_fail++;
            $display("FAIL equal_cnt[%0d]: got %0d/%0d want %0d/%0d",
               i, cyc_o[i], mc_o[i], m_cyc[i], m_mc[i]);
         end
         n_checks++;
         if (fail_o[i] !== m_fail[i] || done_o[i] !== m_stop[i] ||
             lv_o[i] !== (m_n[i] > 0)) begin
            n_fail++;
            $display("FAIL equal_flags[%0d]: got f=%b d=%b v=%b want %b %b %b",
               i, fail_o[i], done_o[i], lv_o[i],
               m_fail[i], m_stop[i], m_n[i] > 0);
         end
      end
   endtask

   task automatic test_first_mismatch();
      logic [7:0] v;
      tick(1, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         v = 8'($urandom);
         tick(0, 1, v, v, 0);
      end
      tick(0, 1, 8'h12, 8'h13, 0);
      n_checks++;
      if (fail_o[0] !== m_fail[0] || done_o[0] !== m_stop[0] ||
          lv_o[0] !== (m_n[0] > 0)) begin
         n_fail++;
         $display("FAIL first_flags: got f=%b d=%b v=%b want %b %b %b",
            fail_o[0], done_o[0], lv_o[0],
            m_fail[0], m_stop[0], m_n[0] > 0);
      end
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (lc_o[i] !== m_lc[i][0] || lg_o[i] !== m_lg[i][0] ||
             lb_o[i] !== m_lb[i][0]) begin
            n_fail++;
            $display("FAIL first_rec[%0d]: got %0d/%h/%h want %0d/%h/%h",
               i, lc_o[i], lg_o[i], lb_o[i],
               m_lc[i][0], m_lg[i][0], m_lb[i][0]);
         end
      end
      for (int k = 0; k < 3; k++) begin
         v = 8'($urandom);
         tick(0, 1, v, ~v, 0);
      end
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (cyc_o[i] !== m_cyc[i] || done_o[i] !== m_stop[i] ||
             mc_o[i] !== m_mc[i]) begin
            n_fail++;
            $display("FAIL after_stop[%0d]: got c=%0d m=%0d d=%b want %0d %0d %b",
               i, cyc_o[i], mc_o[i], done_o[i],
               m_cyc[i], m_mc[i], m_stop[i]);
         end
      end
   endtask

   task automatic test_x_mismatch();
      tick(1, 0, 0, 0, 0);
      tick(0, 1, 8'h00, 8'hxx, 0);
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (mc_o[i] !== m_mc[i] || fail_o[i] !== m_fail[i] ||
             lv_o[i] !== (m_n[i] > 0)) begin
            n_fail++;
            $display("FAIL x_flags[%0d]: got m=%0d f=%b v=%b want %0d %b %b",
               i, mc_o[i], fail_o[i], lv_o[i],
               m_mc[i], m_fail[i], m_n[i] > 0);
         end
         if (m_n[i] > 0) begin
            n_checks++;
            if (lc_o[i] !== m_lc[i][0] || lb_o[i] !== m_lb[i][0]) begin
               n_fail++;
               $display("FAIL x_rec[%0d]: got %0d/%h want %0d/%h",
                  i, lc_o[i], lb_o[i], m_lc[i][0], m_lb[i][0]);
            end
         end
      end
   endtask

   task automatic test_overflow();
      logic [7:0] v;
      tick(1, 0, 0, 0, 0);
      for (int k = 0; k < 5; k++) begin
         v = 8'($urandom);
         tick(0, 1, v, v ^ 8'(1 + $urandom_range(254)), 0);
      end
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (mc_o[i] !== m_mc[i] || ovf_o[i] !== m_ovf[i] ||
             lv_o[i] !== (m_n[i] > 0)) begin
            n_fail++;
            $display("FAIL ovf_flags[%0d]: got m=%0d o=%b v=%b want %0d %b %b",
               i, mc_o[i], ovf_o[i], lv_o[i],
               m_mc[i], m_ovf[i], m_n[i] > 0);
         end
      end
      for (int k = 0; k < 6; k++) begin
         n_checks++;
         if (lv_o[1] !== (m_n[1] > 0)) begin
            n_fail++;
            $display("FAIL drain_valid step %0d: got %b want %b",
               k, lv_o[1], m_n[1] > 0);
         end else if (m_n[1] > 0 && (lc_o[1] !== m_lc[1][0] ||
                      lg_o[1] !== m_lg[1][0] ||
                      lb_o[1] !== m_lb[1][0])) begin
            n_fail++;
            $display("FAIL drain_rec step %0d: got %0d/%h/%h want %0d/%h/%h",
               k, lc_o[1], lg_o[1], lb_o[1],
               m_lc[1][0], m_lg[1][0], m_lb[1][0]);
         end
         tick(0, 0, 0, 0, 1);
      end
   endtask

   task automatic test_full_pushpop();
      logic [7:0] v;
      int exp_n;
      int got_n;
      tick(1, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) begin
         v = 8'($urandom);
         tick(0, 1, v, ~v, 0);
      end
      v = 8'($urandom);
      tick(0, 1, v, ~v, 1);
      n_checks++;
      if (ovf_o[1] !== m_ovf[1] || lc_o[1] !== m_lc[1][0]) begin
         n_fail++;
         $display("FAIL pushpop: got o=%b head=%0d want %b %0d",
            ovf_o[1], lc_o[1], m_ovf[1], m_lc[1][0]);
      end
      exp_n = m_n[1];
      got_n = 0;
      for (int k = 0; k < 8; k++) begin
         if (lv_o[1] === 1'b1) got_n++;
         tick(0, 0, 0, 0, 1);
      end
      n_checks++;
      if (got_n != exp_n) begin
         n_fail++;
         $display("FAIL pushpop_occ: got %0d want %0d", got_n, exp_n);
      end
   endtask

   task automatic test_async_reset();
      logic [7:0] v;
      tick(1, 0, 0, 0, 0);
      for (int k = 0; k < 2; k++) begin
         v = 8'($urandom);
         tick(0, 1, v, ~v, 0);
      end
      #2 rst = 1'b1;
      #1;
      model_clear();
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if ({cyc_o[i], mc_o[i], fail_o[i], done_o[i], lv_o[i],
              ovf_o[i], lc_o[i], lg_o[i], lb_o[i]} !== '0) begin
            n_fail++;
            $display("FAIL async_rst[%0d]: c=%0d m=%0d f=%b d=%b v=%b o=%b want 0",
               i, cyc_o[i], mc_o[i], fail_o[i], done_o[i],
               lv_o[i], ovf_o[i]);
         end
      end
      #3 rst = 1'b0;
      v = 8'($urandom);
      tick(0, 1, v, ~v, 0);
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (lv_o[i] !== (m_n[i] > 0) || lc_o[i] !== m_lc[i][0]) begin
            n_fail++;
            $display("FAIL rst_first_idx[%0d]: got v=%b idx=%0d want %b %0d",
               i, lv_o[i], lc_o[i], m_n[i] > 0, m_lc[i][0]);
         end
      end
      tick(0, 1, v, ~v, 0);
      tick(1, 1, v, ~v, 1);
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (cyc_o[i] !== m_cyc[i] || mc_o[i] !== m_mc[i] ||
             fail_o[i] !== m_fail[i] || done_o[i] !== m_stop[i] ||
             lv_o[i] !== (m_n[i] > 0)) begin
            n_fail++;
            $display("FAIL clear[%0d]: c=%0d m=%0d f=%b d=%b v=%b",
               i, cyc_o[i], mc_o[i], fail_o[i], done_o[i], lv_o[i]);
         end
      end
      tick(0, 1, v, ~v, 0);
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (lc_o[i] !== m_lc[i][0] || cyc_o[i] !== m_cyc[i]) begin
            n_fail++;
            $display("FAIL clr_first_idx[%0d]: got %0d/%0d want %0d/%0d",
               i, lc_o[i], cyc_o[i], m_lc[i][0], m_cyc[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] g;
      logic [7:0] b;
      bit c;
      bit e;
      bit r;
      for (int k = 0; k < 400; k++) begin
         c = ($urandom_range(39) == 0);
         e = ($urandom_range(3) != 0);
         g = 8'($urandom);
         b = ($urandom_range(2) == 0) ? 8'($urandom) : g;
         r = ($urandom_range(2) == 0);
         tick(c, e, g, b, r);
         for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (cyc_o[i] !== m_cyc[i] || mc_o[i] !== m_mc[i] ||
                fail_o[i] !== m_fail[i] || done_o[i] !== m_stop[i] ||
                ovf_o[i] !== m_ovf[i] ||
                lv_o[i] !== (m_n[i] > 0)) begin
               n_fail++;
               $display("FAIL rnd_state[%0d] k=%0d: c=%0d m=%0d f=%b d=%b o=%b v=%b want %0d %0d %b %b %b %b",
                  i, k, cyc_o[i], mc_o[i], fail_o[i], done_o[i],
                  ovf_o[i], lv_o[i], m_cyc[i], m_mc[i], m_fail[i],
                  m_stop[i], m_ovf[i], m_n[i] > 0);
            end
            if (m_n[i] > 0) begin
               n_checks++;
               if (lc_o[i] !== m_lc[i][0] || lg_o[i] !== m_lg[i][0] ||
                   lb_o[i] !== m_lb[i][0]) begin
                  n_fail++;
                  $display("FAIL rnd_rec[%0d] k=%0d: got %0d/%h/%h want %0d/%h/%h",
                     i, k, lc_o[i], lg_o[i], lb_o[i],
                     m_lc[i][0], m_lg[i][0], m_lb[i][0]);
               end
            end
         end
      end
   endtask

   initial begin
      stop_n[0] = 1;
      stop_n[1] = 8;
      model_clear();
      #12 rst = 1'b0;
      #1;
      test_reset();
      @(posedge clk);
      #1;
      test_equal();
      test_first_mismatch();
      test_x_mismatch();
      test_overflow();
      test_full_pushpop();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
         n_checks, n_fail);
      $finish;
   end

endmodule
